// File: rtl/multu_hilo_if.sv
// -----------------------------------------------------------------------------
// multu_hilo_if
// ALU-control-side bus of the sequential MULTU unit.
//   Signal  [5:0]  function code broadcast by the ALU controller
//   dataA   [31:0] multiplicand (sampled on the load cycle only)
//   dataB   [31:0] multiplier   (sampled on the load cycle only)
//   dataOut [31:0] HI on MFHI, LO on MFLO, else 0
//   busy           multiply in progress
//   done           product ready, waiting for the commit code
//   iter    [5:0]  iterations completed for the current multiply (0..32)
// master: the controller/datapath side; slave: the multiplier.
// -----------------------------------------------------------------------------
interface multu_hilo_if;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;
  logic [5:0]  iter;

  modport master (
    output Signal, dataA, dataB,
    input  dataOut, busy, done, iter
  );

  modport slave (
    input  Signal, dataA, dataB,
    output dataOut, busy, done, iter
  );
endinterface

// File: rtl/multu_hilo.sv
// -----------------------------------------------------------------------------
// multu_hilo
// Sequential 32x32 unsigned shift-add multiplier with its HI/LO register pair.
// One iteration is performed per clock while MULTU (25) is presented; after 32
// consecutive MULTU edges the product waits in DONE until the commit code (63)
// copies it into HI/LO. MFHI (16) / MFLO (18) read HI/LO combinationally.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (highest priority, usable mid-run)
//   bus    multu_hilo_if.slave: Signal/dataA/dataB in,
//          dataOut/busy/done/iter out
// -----------------------------------------------------------------------------
module multu_hilo (
  input  logic          clk,
  input  logic          reset,
  multu_hilo_if.slave   bus
);

  // Function codes decoded from the ALU control broadcast.
  localparam logic [5:0] FN_MULTU  = 6'd25;
  localparam logic [5:0] FN_COMMIT = 6'd63;
  localparam logic [5:0] FN_MFHI   = 6'd16;
  localparam logic [5:0] FN_MFLO   = 6'd18;

  localparam logic [5:0] LAST_ITER = 6'd31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // State registers
  state_t      r_state;
  logic [31:0] r_mcand;
  logic [63:0] r_prod;   // [63:32] partial sum, [31:0] remaining multiplier bits
  logic [5:0]  r_iter;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Next-state values
  state_t      w_state_nxt;
  logic [31:0] w_mcand_nxt;
  logic [63:0] w_prod_nxt;
  logic [5:0]  w_iter_nxt;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;

  // Decoded codes
  logic w_is_multu;
  logic w_is_commit;

  // Iteration datapath
  logic        w_load;
  logic [63:0] w_src_prod;
  logic [31:0] w_src_mcand;
  logic [32:0] w_addend;
  logic [32:0] w_sum33;
  logic [63:0] w_step_prod;

  assign w_is_multu  = (bus.Signal == FN_MULTU);
  assign w_is_commit = (bus.Signal == FN_COMMIT);

  // ---------------------------------------------------------------------------
  // Single shared iteration step. On a load cycle (MULTU outside RUN) the step
  // runs directly on the fresh operands so iteration 0 happens in the same
  // clock as the load; otherwise it continues from the registered product.
  // ---------------------------------------------------------------------------
  assign w_load      = (r_state != ST_RUN) && w_is_multu;
  assign w_src_prod  = w_load ? {32'h0, bus.dataB} : r_prod;
  assign w_src_mcand = w_load ? bus.dataA : r_mcand;

  // The carry out of the 32-bit add is kept as bit 32 and shifts into [63].
  assign w_addend    = w_src_prod[0] ? {1'b0, w_src_mcand} : 33'd0;
  assign w_sum33     = {1'b0, w_src_prod[63:32]} + w_addend;
  assign w_step_prod = {w_sum33, w_src_prod[31:1]};

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_mcand_nxt = r_mcand;
    w_prod_nxt  = r_prod;
    w_iter_nxt  = r_iter;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;

    unique case (r_state)
      ST_IDLE: begin
        // Commit and every other code are ignored while idle.
        if (w_is_multu) begin
          w_mcand_nxt = bus.dataA;
          w_prod_nxt  = w_step_prod;
          w_iter_nxt  = 6'd1;
          w_state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (w_is_multu) begin
          w_prod_nxt = w_step_prod;
          w_iter_nxt = r_iter + 6'd1;
          if (r_iter == LAST_ITER) begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          // Any break in the MULTU stream abandons the multiply; a premature
          // commit lands here too and must not touch HI/LO.
          w_iter_nxt  = 6'd0;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_DONE: begin
        if (w_is_commit) begin
          w_hi_nxt    = r_prod[63:32];
          w_lo_nxt    = r_prod[31:0];
          w_iter_nxt  = 6'd0;
          w_state_nxt = ST_IDLE;
        end else if (w_is_multu) begin
          // Restart: the uncommitted product is discarded.
          w_mcand_nxt = bus.dataA;
          w_prod_nxt  = w_step_prod;
          w_iter_nxt  = 6'd1;
          w_state_nxt = ST_RUN;
        end
        // Any other code (reads included) holds the finished product.
      end

      default: begin
        w_iter_nxt  = 6'd0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_state <= ST_IDLE;
      r_mcand <= 32'h0;
      r_prod  <= 64'h0;
      r_iter  <= 6'd0;
      r_hi    <= 32'h0;
      r_lo    <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_mcand <= w_mcand_nxt;
      r_prod  <= w_prod_nxt;
      r_iter  <= w_iter_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = (r_state == ST_DONE);
  assign bus.iter = r_iter;

  // Reads come straight from the committed pair, so they stay stable while a
  // new multiply is running.
  always_comb begin
    bus.dataOut = 32'h0;
    if (bus.Signal == FN_MFHI) begin
      bus.dataOut = r_hi;
    end else if (bus.Signal == FN_MFLO) begin
      bus.dataOut = r_lo;
    end
  end

endmodule

// File: tb/tb_multu_hilo.sv
// -----------------------------------------------------------------------------
// tb_multu_hilo
// Self-checking bench for multu_hilo. A behavioural model tracks the unit as
// "count of consecutive MULTU codes + captured operands + committed HI/LO" and
// computes the product with plain 64-bit multiplication. Every clock the bench
// compares iter/busy/done/dataOut against the model; directed tables and
// sequences add hand-computed constant checks.
// -----------------------------------------------------------------------------
module tb_multu_hilo;

  localparam logic [5:0] MULTU  = 6'd25;
  localparam logic [5:0] COMMIT = 6'd63;
  localparam logic [5:0] MFHI   = 6'd16;
  localparam logic [5:0] MFLO   = 6'd18;
  localparam logic [5:0] ADD    = 6'd32;

  logic clk = 1'b0;
  logic reset;

  multu_hilo_if bus ();

  multu_hilo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_cnt;   // consecutive MULTU edges of current multiply (0..32)
  logic [31:0] m_a, m_b;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [5:0] sig,
                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (rst) begin
      m_cnt = 0; m_a = '0; m_b = '0; m_hi = '0; m_lo = '0;
    end else if (sig == MULTU) begin
      if (m_cnt == 0 || m_cnt == 32) begin
        m_a = a; m_b = b; m_cnt = 1;
      end else begin
        m_cnt++;
      end
    end else if (m_cnt == 32) begin
      if (sig == COMMIT) begin
        p = 64'(m_a) * 64'(m_b);
        m_hi = p[63:32];
        m_lo = p[31:0];
        m_cnt = 0;
      end
    end else begin
      m_cnt = 0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] sig);
    if (sig == MFHI) return m_hi;
    if (sig == MFLO) return m_lo;
    return 32'h0;
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic tick(input logic rst, input logic [5:0] sig,
                      input logic [31:0] a = 32'h0, input logic [31:0] b = 32'h0);
    reset      = rst;
    bus.Signal = sig;
    bus.dataA  = a;
    bus.dataB  = b;
    @(posedge clk);
    model_edge(rst, sig, a, b);
    #1;
    check("iter",    64'(bus.iter),    64'(m_cnt));
    check("busy",    64'(bus.busy),    64'(m_cnt >= 1 && m_cnt <= 31));
    check("done",    64'(bus.done),    64'(m_cnt == 32));
    check("dataOut", 64'(bus.dataOut), 64'(model_read(sig)));
  endtask

  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input int n);
    for (int k = 0; k < n; k++) tick(1'b0, MULTU, a, b);
  endtask

  task automatic read_expect(input logic [31:0] hi, input logic [31:0] lo, input string tag);
    tick(1'b0, MFHI);
    check({tag, "_hi"}, 64'(bus.dataOut), 64'(hi));
    tick(1'b0, MFLO);
    check({tag, "_lo"}, 64'(bus.dataOut), 64'(lo));
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000};
    vecs[3] = '{32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[5] = '{32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

    m_cnt = 0; m_a = '0; m_b = '0; m_hi = '0; m_lo = '0;
    reset = 1'b1; bus.Signal = '0; bus.dataA = '0; bus.dataB = '0;

    // Power-on reset
    tick(1'b1, 6'd0);
    tick(1'b1, MFHI);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_iter", 64'(bus.iter), 64'd0);
    check("rst_mfhi", 64'(bus.dataOut), 64'd0);

    // Table-driven full multiplies
    foreach (vecs[i]) begin
      run_mult(vecs[i].a, vecs[i].b, 32);
      check("done_at_32", 64'(bus.done), 64'd1);
      tick(1'b0, COMMIT);
      check("post_commit_iter", 64'(bus.iter), 64'd0);
      read_expect(vecs[i].hi, vecs[i].lo, "vec");
    end

    // Reset mid-RUN with MULTU still presented
    run_mult(32'h0000_0007, 32'h0000_0009, 5);
    tick(1'b1, MULTU, 32'h7, 32'h9);
    tick(1'b1, MULTU, 32'h7, 32'h9);
    tick(1'b0, MFHI);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_iter", 64'(bus.iter), 64'd0);
    check("rst_mid_hi",   64'(bus.dataOut), 64'd0);
    tick(1'b0, MFLO);
    check("rst_mid_lo",   64'(bus.dataOut), 64'd0);

    // Abort: commit 3x5, then break a run at iter=10 with ADD
    run_mult(32'd3, 32'd5, 32);
    tick(1'b0, COMMIT);
    run_mult(32'h0001_0000, 32'h0001_0000, 10);
    check("abort_iter10", 64'(bus.iter), 64'd10);
    tick(1'b0, ADD);
    check("abort_iter0", 64'(bus.iter), 64'd0);
    check("abort_busy",  64'(bus.busy), 64'd0);
    read_expect(32'd0, 32'd15, "abort");
    tick(1'b0, COMMIT);
    read_expect(32'd0, 32'd15, "abort_commit");

    // Premature commits: in IDLE and at iter=20
    tick(1'b0, COMMIT);
    run_mult(32'hFFFF_FFFF, 32'h2, 20);
    tick(1'b0, COMMIT);
    check("prem_iter", 64'(bus.iter), 64'd0);
    check("prem_done", 64'(bus.done), 64'd0);
    read_expect(32'd0, 32'd15, "prem");

    // Restart from DONE: 7x6 never committed, 9x9 committed
    run_mult(32'd7, 32'd6, 32);
    tick(1'b0, MFLO);
    check("done_hold",   64'(bus.done), 64'd1);
    check("done_old_lo", 64'(bus.dataOut), 64'd15);
    run_mult(32'd9, 32'd9, 1);
    check("restart_iter", 64'(bus.iter), 64'd1);
    run_mult(32'd9, 32'd9, 31);
    tick(1'b0, COMMIT);
    read_expect(32'd0, 32'd81, "restart");

    // Randomized mixed traffic against the model
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a, b;
      int n, pick;
      a = $urandom;
      b = $urandom;
      if (t % 4 == 0) a = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      n = (t % 3 == 0) ? $urandom_range(1, 40) : 32;
      run_mult(a, b, n);
      pick = $urandom_range(0, 5);
      case (pick)
        0, 1, 2: tick(1'b0, COMMIT);
        3:       tick(1'b0, MFHI);
        4:       tick(1'b0, ADD);
        default: tick(1'b0, 6'($urandom_range(0, 63)));
      endcase
      tick(1'b0, MFHI);
      tick(1'b0, MFLO);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multu_hilo.md
# multu_hilo

Sequential 32-bit unsigned shift-add multiplier with its HI/LO result register pair. It sits on the ALU control bus and consumes the 6-bit function code broadcast by the ALU controller. It performs one multiply iteration per clock while MULTU (25) is presented, commits the 64-bit product to HI/LO when the commit code 6'b111111 (63) arrives, and serves MFHI/MFLO reads back to the datapath mux.

## Interface
- No parameters. Widths are fixed: 32-bit operands, 64-bit product, 32 iterations.
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- Signal  input  6  function code from ALU control. Decoded codes: MULTU 25, commit 63, MFHI 16, MFLO 18. All other codes count as "other".
- dataA  input  32  multiplicand; sampled only on the load cycle.
- dataB  input  32  multiplier; sampled only on the load cycle.
- dataOut  output  32  HI when Signal==16, LO when Signal==18, else 0. Combinational from the HI/LO registers.
- busy  output  1  high in RUN.
- done  output  1  high in DONE; product ready, awaiting commit.
- iter  output  6  iterations completed for the current multiply, 0..32.

## Operation
- State machine: IDLE, RUN, DONE.
- Internal registers:
  - mcand[31:0]: multiplicand.
  - prod[63:0]: upper half is the partial sum, lower half is the remaining multiplier bits.
  - iter[5:0].
  - hi[31:0] and lo[31:0].
- Iteration step: sum33 = {1'b0,prod[63:32]} + (prod[0] ? {1'b0,mcand} : 0), then prod <= {sum33, prod[31:1]}. Arithmetic is unsigned and the carry is kept in the 33-bit sum.
- IDLE:
  - Signal==25: load mcand=dataA. Perform iteration 0 directly on prod={32'h0,dataB} in the same cycle. Set iter=1 and go to RUN.
  - Any other code: stay in IDLE. Commit (63) is ignored and hi/lo are unchanged.
- RUN:
  - Signal==25: perform one iteration and increment iter.
    - If the new iter==32, go to DONE.
  - Signal!=25: abort. Go to IDLE with iter=0; hi/lo unchanged. A premature 63 also aborts and does not commit.
- DONE:
  - Signal==63: hi<=prod[63:32], lo<=prod[31:0], iter<=0, go to IDLE.
  - Signal==25: restart. Reload operands exactly as from IDLE and go to RUN; the previous product is discarded.
  - Any other code (MFHI/MFLO included): hold in DONE. prod is kept and reads return the old hi/lo.
- In IDLE and DONE, prod and mcand hold their values.

## Timing
- Reset (synchronous, highest priority, usable mid-operation):
  - state=IDLE; iter=0; prod=0; mcand=0; hi=0; lo=0.
  - Resulting outputs: busy=0, done=0, dataOut=0 for all Signal values.
- Latency from the first MULTU edge:
  - done is asserted after exactly 32 consecutive MULTU clock edges.
  - iter reads 1..32 after edges 1..32.
- Commit:
  - The 63 code is sampled on the next edge after done is seen.
  - hi/lo are visible on dataOut from the following cycle; MFHI/MFLO are combinational in that cycle.
- This timing matches a controller that holds MULTU for 32 edges and then issues 63 for one cycle.
- Commit and MULTU cannot coincide because the 6-bit code is one-hot in meaning. No arbitration is needed.
- Reading during RUN returns the previous committed hi/lo, which remain stable.

## Test plan
- Reset: assert reset for 2 cycles mid-RUN with Signal=25 -> next cycle busy=0, done=0, iter=0; MFHI and MFLO both read 0.
- Basic multiply: dataA=3, dataB=5, Signal=25 for 32 cycles, then 63 for 1 cycle -> done high after edge 32; MFHI=0x00000000 and MFLO=0x0000000F.
- Carry path: dataA=dataB=0xFFFFFFFF, full sequence -> HI=0xFFFFFFFE, LO=0x00000001. Also dataA=0x80000000, dataB=2 -> HI=1, LO=0.
- Abort: prior commit leaves HI/LO=0/15. Start 0x10000×0x10000, drop Signal to 32 (ADD) after iter=10 -> IDLE, iter=0, MFHI/MFLO still 0/15. Issue 63 next -> no change.
- Premature commit: Signal=63 in IDLE, and Signal=63 at iter=20 -> hi/lo unchanged; FSM ends in IDLE with done never asserted.
- Restart from DONE: complete 7×6 without commit, then issue Signal=25 with dataA=9, dataB=9 for 32 cycles, then 63 -> LO=81, HI=0 (42 never committed).
